// File: rtl/timer_irq_ctrl_if.sv
// Peripheral-bus bundle for the machine-timer controller: 32-bit register reads,
// byte-masked writes.
interface timer_irq_ctrl_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [7:0]  write_mask_in;
  logic [63:0] write_value_in;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, 2-stage compare pipeline and
// an interrupt FSM that masks the irq while mtimecmp is rewritten low-then-high.
module timer_irq_ctrl #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_ctrl_if.slave  bus,
  output logic             irq_out
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_FIRED    = 2'b10,
    ST_UPDATING = 2'b11
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = cur;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) res[8*k +: 8] = wdat[8*k +: 8];
    end
    return res;
  endfunction

  state_t                    state, state_next;
  logic [63:0]               mtime, mtimecmp;
  logic                      ctrl_en;
  logic [PRESCALE_WIDTH-1:0] prescale, psc_cnt;
  logic                      lo_ge_p1, hi_gt_p1, hi_eq_p1, vld_p1;
  logic                      ge_p2, vld_p2;

  logic [2:0]  idx;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        wr, wr_mtl, wr_mth, wr_cl, wr_ch, wr_ctrl, wr_mtime, clear;
  logic        wrap, tick;
  logic [31:0] ctrl_word, ctrl_new, rd;

  assign idx      = bus.address_in[4:2];
  assign mask     = bus.write_mask_in[3:0];
  assign wdata    = bus.write_value_in[31:0];
  assign wr       = bus.sel_in & (|mask);
  assign wr_mtl   = wr & (idx == 3'd0);
  assign wr_mth   = wr & (idx == 3'd1);
  assign wr_cl    = wr & (idx == 3'd2);
  assign wr_ch    = wr & (idx == 3'd3);
  assign wr_ctrl  = wr & (idx == 3'd4);
  assign wr_mtime = wr_mtl | wr_mth;
  assign clear    = wr_mtime | wr_cl | wr_ch;

  // A direct mtime write takes precedence over the tick in the same cycle.
  assign wrap = (psc_cnt >= prescale);
  assign tick = ctrl_en & wrap & ~wr_mtime;

  always_comb begin
    ctrl_word                        = '0;
    ctrl_word[0]                     = ctrl_en;
    ctrl_word[8 +: PRESCALE_WIDTH]   = prescale;
  end

  assign ctrl_new = merge_bytes(ctrl_word, wdata, mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      ctrl_en  <= 1'b0;
      prescale <= '0;
      psc_cnt  <= '0;
    end else begin
      if (wr_mtl)      mtime[31:0]  <= merge_bytes(mtime[31:0], wdata, mask);
      else if (wr_mth) mtime[63:32] <= merge_bytes(mtime[63:32], wdata, mask);
      else if (tick)   mtime        <= mtime + 64'd1;

      if (wr_mtime)     psc_cnt <= '0;
      else if (ctrl_en) psc_cnt <= wrap ? '0 : psc_cnt + PRESCALE_WIDTH'(1);

      if (wr_cl) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wdata, mask);
      if (wr_ch) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, mask);

      if (wr_ctrl) begin
        ctrl_en  <= ctrl_new[0];
        prescale <= ctrl_new[8 +: PRESCALE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_ge_p1 <= 1'b0;
      hi_gt_p1 <= 1'b0;
      hi_eq_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      ge_p2    <= 1'b0;
      vld_p2   <= 1'b0;
      irq_out  <= 1'b0;
    end else begin
      // Stage 1: split compare of the pre-increment mtime against mtimecmp
      lo_ge_p1 <= (mtime[31:0] >= mtimecmp[31:0]);
      hi_gt_p1 <= (mtime[63:32] > mtimecmp[63:32]);
      hi_eq_p1 <= (mtime[63:32] == mtimecmp[63:32]);
      vld_p1   <= ctrl_en & ~clear;
      // Stage 2: combine halves
      ge_p2    <= hi_gt_p1 | (hi_eq_p1 & lo_ge_p1);
      vld_p2   <= vld_p1 & ~clear;
      // Output register: gated by the state being entered so disable/update drop it at once
      irq_out  <= ge_p2 & vld_p2 & ~clear &
                  ((state_next == ST_RUNNING) | (state_next == ST_FIRED));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_DISABLED;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUNNING: begin
        if (wr_cl)                state_next = ST_UPDATING;
        else if (vld_p2 & ge_p2)  state_next = ST_FIRED;
      end
      ST_FIRED: begin
        if (wr_cl)                state_next = ST_UPDATING;
        else if (vld_p2 & ~ge_p2) state_next = ST_RUNNING;
      end
      ST_UPDATING: begin
        if (wr_ch)                state_next = ST_RUNNING;
      end
      default: ;
    endcase
    if (wr_ctrl) begin
      if (!ctrl_new[0])              state_next = ST_DISABLED;
      else if (state == ST_DISABLED) state_next = ST_RUNNING;
    end
  end

  always_comb begin
    rd = '0;
    if (bus.sel_in) begin
      case (idx)
        3'd0:    rd = mtime[31:0];
        3'd1:    rd = mtime[63:32];
        3'd2:    rd = mtimecmp[31:0];
        3'd3:    rd = mtimecmp[63:32];
        3'd4:    rd = ctrl_word;
        3'd5:    rd = {28'd0, state, (state == ST_UPDATING), irq_out};
        default: rd = '0;
      endcase
    end
  end

  assign bus.read_value_out = rd;

  logic unused_bits;
  assign unused_bits = ^{bus.read_in, bus.address_in[31:5], bus.address_in[1:0],
                         bus.write_mask_in[7:4], bus.write_value_in[63:32],
                         ctrl_new[31:8+PRESCALE_WIDTH], ctrl_new[7:1]};

endmodule
